// File: rtl/psum_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psum_accumulator_pkg
// Description : Shared widths, saturation bounds and helpers for the
//               partial-sum accumulator and its requantizer.
// Revision    : 1.0 - initial release
// ============================================================================
package psum_accumulator_pkg;

  localparam int LANES   = 8;   // partial-sum lanes per tile
  localparam int PSUM_W  = 21;  // incoming signed partial-sum width
  localparam int ACC_W   = 32;  // per-lane accumulator width
  localparam int OUT_W   = 8;   // requantized output width
  localparam int CNT_W   = 8;   // tile counter / cfg_num_tiles width
  localparam int SHIFT_W = 5;   // arithmetic shift field width

  localparam int SAT_MAX = 127;   // int8 upper bound
  localparam int SAT_MIN = -128;  // int8 lower bound

  // Sign-extend one incoming partial sum to accumulator width.
  function automatic logic [ACC_W-1:0] sext_psum(input logic [PSUM_W-1:0] p);
    return {{(ACC_W-PSUM_W){p[PSUM_W-1]}}, p};
  endfunction

endpackage
`default_nettype wire

// File: rtl/psum_requant.sv
`default_nettype none
// ============================================================================
// Module      : psum_requant
// Description : Combinational per-lane requantizer: arithmetic right shift,
//               optional ReLU, saturation to signed int8.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_requant
  import psum_accumulator_pkg::*;
(
  input  logic [ACC_W-1:0]   sum,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               relu,
  output logic [OUT_W-1:0]   q
);

  localparam logic signed [ACC_W-1:0] C_HI = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] C_LO = ACC_W'(SAT_MIN);

  logic signed [ACC_W-1:0] w_shifted;

  assign w_shifted = $signed(sum) >>> shift;

  // ReLU first, then clamp into the int8 range.
  always_comb begin
    q = w_shifted[OUT_W-1:0];
    if (relu && (w_shifted < 0)) begin
      q = '0;
    end else if (w_shifted > C_HI) begin
      q = C_HI[OUT_W-1:0];
    end else if (w_shifted < C_LO) begin
      q = C_LO[OUT_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/psum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : psum_accumulator
// Description : Accumulates 8-lane partial sums over a configurable number of
//               tiles, requantizes to int8 and hands results downstream over
//               a valid/ready handshake. Next group accumulates while a
//               result is pending; only the completing beat can stall.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_accumulator
  import psum_accumulator_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*PSUM_W-1:0] in_psum,
  input  logic [CNT_W-1:0]        cfg_num_tiles,
  input  logic [SHIFT_W-1:0]      cfg_shift,
  input  logic                    cfg_relu,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*OUT_W-1:0]  out_data,
  output logic                    busy
);

  logic [CNT_W-1:0]        r_tile_cnt;
  logic [CNT_W-1:0]        r_num_tiles_l;
  logic [SHIFT_W-1:0]      r_shift_l;
  logic                    r_relu_l;
  logic [ACC_W-1:0]        r_acc [LANES];
  logic                    r_out_valid;
  logic [LANES*OUT_W-1:0]  r_out_data;

  logic                    w_first;
  logic [CNT_W-1:0]        w_cfg_tiles;
  logic [CNT_W-1:0]        w_num_eff;
  logic [SHIFT_W-1:0]      w_shift_eff;
  logic                    w_relu_eff;
  logic                    w_last;
  logic                    w_accept;
  logic [ACC_W-1:0]        w_sum [LANES];
  logic [LANES*OUT_W-1:0]  w_q;

  // A beat at tile_cnt==0 opens a group and uses the live config; later
  // beats use the values latched when the group opened. Using the live
  // value on the opening beat means a 1-tile group is recognised as
  // completing (and stalled if needed) even if the previous group differed.
  assign w_first     = (r_tile_cnt == '0);
  assign w_cfg_tiles = (cfg_num_tiles == '0) ? CNT_W'(1) : cfg_num_tiles;
  assign w_num_eff   = w_first ? w_cfg_tiles : r_num_tiles_l;
  assign w_shift_eff = w_first ? cfg_shift   : r_shift_l;
  assign w_relu_eff  = w_first ? cfg_relu    : r_relu_l;
  assign w_last      = (r_tile_cnt == (w_num_eff - CNT_W'(1)));

  // Only the group-completing beat needs a free output slot.
  assign in_ready = !(r_out_valid && !out_ready && w_last);
  assign w_accept = in_valid && in_ready;

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign w_sum[i] = w_first ? sext_psum(in_psum[i*PSUM_W +: PSUM_W])
                                : r_acc[i] + sext_psum(in_psum[i*PSUM_W +: PSUM_W]);

      psum_requant u_requant (
        .sum   (w_sum[i]),
        .shift (w_shift_eff),
        .relu  (w_relu_eff),
        .q     (w_q[i*OUT_W +: OUT_W])
      );
    end
  endgenerate

  // Per-lane accumulators: restart on the opening beat, add otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        r_acc[i] <= '0;
      end
    end else if (w_accept) begin
      for (int i = 0; i < LANES; i++) begin
        r_acc[i] <= w_sum[i];
      end
    end
  end

  // Tile counter and config latched at the start of each group.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tile_cnt    <= '0;
      r_num_tiles_l <= CNT_W'(1);
      r_shift_l     <= '0;
      r_relu_l      <= 1'b0;
    end else if (w_accept) begin
      if (w_first) begin
        r_num_tiles_l <= w_cfg_tiles;
        r_shift_l     <= cfg_shift;
        r_relu_l      <= cfg_relu;
      end
      r_tile_cnt <= w_last ? '0 : r_tile_cnt + CNT_W'(1);
    end
  end

  // Output slot: load on group completion, release on downstream accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept && w_last) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_q;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = !w_first;

endmodule
`default_nettype wire
